// File: rtl/booth_r8_mac_seq.sv
// Iterative radix-8 Booth multiplier / multiply-accumulator with valid/ready handshakes.
// Each transaction takes one precompute cycle plus G recode cycles; the result register doubles as the accumulator.
module booth_r8_mac_seq #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             is_signed,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             busy
);
    localparam int G  = (N+3)/3;
    localparam int RW = 3*G+1;
    localparam int KW = $clog2(G+1);

    typedef enum logic [1:0] {IDLE, PRECOMP, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      a_q, a_d, b_q, b_d;
    logic              sgn_q, sgn_d, accm_q, accm_d;
    logic [ACC_W-1:0]  m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, m4_q, m4_d;
    logic [RW-1:0]     r_q, r_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic [N:0]        a_ext;
    logic [ACC_W-1:0]  m1_ext, sel, sel_sh, sum_nxt;

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds its data stable while valid is high and ready is low.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        accm_d      = accm_q;
        m1_d        = m1_q;
        m2_d        = m2_q;
        m3_d        = m3_q;
        m4_d        = m4_q;
        r_d         = r_q;
        sum_d       = sum_q;
        k_d         = k_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        a_ext  = {sgn_q & a_q[N-1], a_q};
        m1_ext = {{(ACC_W-N-1){a_ext[N]}}, a_ext};

        // Low four bits of the shifting recode vector form the current overlapping Booth group.
        case (r_q[3:0])
            4'b0001, 4'b0010: sel = m1_q;
            4'b0011, 4'b0100: sel = m2_q;
            4'b0101, 4'b0110: sel = m3_q;
            4'b0111:          sel = m4_q;
            4'b1000:          sel = -m4_q;
            4'b1001, 4'b1010: sel = -m3_q;
            4'b1011, 4'b1100: sel = -m2_q;
            4'b1101, 4'b1110: sel = -m1_q;
            default:          sel = '0;
        endcase
        sel_sh  = sel << (3 * k_q);
        sum_nxt = sum_q + sel_sh;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    accm_d  = acc_mode;
                    state_d = PRECOMP;
                end
            end
            PRECOMP: begin
                m1_d    = m1_ext;
                m2_d    = m1_ext << 1;
                m3_d    = m1_ext + (m1_ext << 1);
                m4_d    = m1_ext << 2;
                r_d     = {{(RW-N-1){sgn_q & b_q[N-1]}}, b_q, 1'b0};
                sum_d   = '0;
                k_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d = sum_nxt;
                r_d   = r_q >> 3;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(G-1)) begin
                    result_d    = accm_q ? result_q + sum_nxt : sum_nxt;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            accm_q      <= 1'b0;
            m1_q        <= '0;
            m2_q        <= '0;
            m3_q        <= '0;
            m4_q        <= '0;
            r_q         <= '0;
            sum_q       <= '0;
            k_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            accm_q      <= accm_d;
            m1_q        <= m1_d;
            m2_q        <= m2_d;
            m3_q        <= m3_d;
            m4_q        <= m4_d;
            r_q         <= r_d;
            sum_q       <= sum_d;
            k_q         <= k_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_booth_r8_mac_seq.sv
// Bench for booth_r8_mac_seq: an N=8 and an N=16 instance share stimulus; results are compared
// against an arithmetic product/accumulate model, a constant vector table and handshake corner sequences.
module tb_booth_r8_mac_seq;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_in, b_in;
    logic        s_in, m_in;
    logic        sel16;

    logic        iv8, iv16;
    logic        ir8, ov8, busy8;
    logic        ir16, ov16, busy16;
    logic [23:0] res8;
    logic [39:0] res16;

    logic        cur_ov, cur_ir, cur_busy;
    logic [63:0] cur_res;

    int          checks;
    int          failures;
    logic [63:0] exp_q[$];
    logic [63:0] acc8, acc16;

    assign iv8      = in_valid & ~sel16;
    assign iv16     = in_valid & sel16;
    assign cur_ov   = sel16 ? ov16   : ov8;
    assign cur_ir   = sel16 ? ir16   : ir8;
    assign cur_busy = sel16 ? busy16 : busy8;
    assign cur_res  = sel16 ? {24'b0, res16} : {40'b0, res8};

    booth_r8_mac_seq #(.N(8), .ACC_W(24)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .a(a_in[7:0]), .b(b_in[7:0]), .is_signed(s_in), .acc_mode(m_in),
        .out_valid(ov8), .out_ready(out_ready), .result(res8), .busy(busy8)
    );

    booth_r8_mac_seq #(.N(16), .ACC_W(40)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .a(a_in[15:0]), .b(b_in[15:0]), .is_signed(s_in), .acc_mode(m_in),
        .out_valid(ov16), .out_ready(out_ready), .result(res16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    typedef struct {
        logic        is16;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        m;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input int n);
        logic [31:0] mask;
        mask = (32'd1 << n) - 32'd1;
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'd1 << (n - 1);
            default: return $urandom & mask;
        endcase
    endfunction

    // Issue one transaction at a negedge, wait for the result, optionally stall the output, then hand it off.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic s, input logic m,
                          input int hold, output logic [63:0] res, output int lat);
        logic [63:0] held;
        chk("in_ready_idle", 64'(cur_ir), 64'd1);
        a_in = ia; b_in = ib; s_in = s; m_in = m;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a_in = $urandom; b_in = $urandom;
        s_in = 1'($urandom_range(0, 1)); m_in = 1'($urandom_range(0, 1));
        lat = 0;
        while (!cur_ov && lat < 40) begin
            if (cur_ir) begin
                chk("in_ready_busy", 64'(cur_ir), 64'd0);
            end
            @(negedge clk);
            lat++;
        end
        chk("out_valid_rise", 64'(cur_ov), 64'd1);
        held = cur_res;
        for (int h = 0; h < hold; h++) begin
            a_in = $urandom; b_in = $urandom;
            s_in = 1'($urandom_range(0, 1)); m_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_result", cur_res, held);
            chk("hold_out_valid", 64'(cur_ov), 64'd1);
            chk("hold_in_ready", 64'(cur_ir), 64'd0);
            chk("hold_busy", 64'(cur_busy), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", 64'(cur_ov), 64'd0);
        chk("in_ready_after_hs", 64'(cur_ir), 64'd1);
        chk("result_kept", cur_res, held);
        res = held;
    endtask

    // Reference: integer product of the operands interpreted per mode, optionally added to the running total.
    task automatic apply(input logic [31:0] ia, input logic [31:0] ib, input logic s, input logic m,
                         input int hold, output logic [63:0] res);
        int          n, accw, lat;
        longint      va, vb;
        logic [31:0] omask;
        logic [63:0] mask, prod, base, expv, got;
        n     = sel16 ? 16 : 8;
        accw  = sel16 ? 40 : 24;
        omask = (32'd1 << n) - 32'd1;
        mask  = (64'd1 << accw) - 64'd1;
        va = longint'(ia & omask);
        vb = longint'(ib & omask);
        if (s && ia[n-1]) va = va - (longint'(1) << n);
        if (s && ib[n-1]) vb = vb - (longint'(1) << n);
        prod = 64'(va * vb) & mask;
        base = sel16 ? acc16 : acc8;
        expv = m ? ((base + prod) & mask) : prod;
        exp_q.push_back(expv);
        if (sel16) acc16 = expv;
        else       acc8  = expv;
        run_op(ia, ib, s, m, hold, got, lat);
        chk("result", got, exp_q.pop_front());
        chk("latency", 64'(lat), sel16 ? 64'd7 : 64'd4);
        res = got;
    endtask

    initial begin
        logic [63:0] r;
        checks = 0; failures = 0;
        acc8 = '0; acc16 = '0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; s_in = 1'b0; m_in = 1'b0; sel16 = 1'b0;

        vecs[0]  = '{1'b0, 32'h80,   32'h80,   1'b1, 1'b0, 64'd16384};
        vecs[1]  = '{1'b0, 32'hFF,   32'hFF,   1'b0, 1'b0, 64'd65025};
        vecs[2]  = '{1'b0, 32'hFF,   32'hFF,   1'b1, 1'b0, 64'd1};
        vecs[3]  = '{1'b0, 32'd7,    32'hFD,   1'b1, 1'b0, 64'hFFFFEB};
        vecs[4]  = '{1'b0, 32'd100,  32'd100,  1'b1, 1'b1, 64'd9979};
        vecs[5]  = '{1'b0, 32'h80,   32'd127,  1'b1, 1'b1, 64'hFFE77B};
        vecs[6]  = '{1'b0, 32'd0,    32'd200,  1'b0, 1'b0, 64'd0};
        vecs[7]  = '{1'b0, 32'd128,  32'd255,  1'b0, 1'b0, 64'd32640};
        vecs[8]  = '{1'b0, 32'd127,  32'd127,  1'b1, 1'b0, 64'd16129};
        vecs[9]  = '{1'b0, 32'h80,   32'd1,    1'b1, 1'b0, 64'hFFFF80};
        vecs[10] = '{1'b0, 32'd255,  32'd1,    1'b0, 1'b1, 64'd127};
        vecs[11] = '{1'b0, 32'hFF,   32'hFF,   1'b0, 1'b1, 64'd65152};
        vecs[12] = '{1'b1, 32'h8000, 32'h8000, 1'b1, 1'b0, 64'd1073741824};
        vecs[13] = '{1'b1, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0, 64'd4294836225};
        vecs[14] = '{1'b1, 32'hFFFF, 32'd2,    1'b1, 1'b1, 64'd4294836223};

        // Reset state of both instances.
        @(negedge clk);
        chk("rst_in_ready8", 64'(ir8), 64'd1);
        chk("rst_out_valid8", 64'(ov8), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_result8", 64'(res8), 64'd0);
        chk("rst_in_ready16", 64'(ir16), 64'd1);
        chk("rst_result16", 64'(res16), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            sel16 = vecs[i].is16;
            apply(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, 0, r);
            chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // Output backpressure for ten cycles with inputs toggling underneath.
        sel16 = 1'b0;
        apply(32'd77, 32'hC3, 1'b1, 1'b0, 10, r);

        // Reset while in RUN with k=1 aborts the operation and clears the accumulator.
        a_in = 32'd9; b_in = 32'd9; s_in = 1'b0; m_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 64'(busy8), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_result", 64'(res8), 64'd0);
        chk("midrst_out_valid", 64'(ov8), 64'd0);
        chk("midrst_in_ready", 64'(ir8), 64'd1);
        chk("midrst_busy", 64'(busy8), 64'd0);
        acc8 = '0; acc16 = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", 64'(ov8), 64'd0);
        apply(32'd3, 32'd5, 1'b1, 1'b1, 0, r);
        chk("after_reset_3x5", r, 64'd15);

        for (int i = 0; i < 1200; i++) begin
            apply(pick(8), pick(8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), r);
        end
        sel16 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            apply(pick(16), pick(16), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/booth_r8_mac_seq.md
Name: booth_r8_mac_seq

Overview:
- Iterative radix-8 Booth multiply/multiply-accumulate unit. It is the parametrised successor of the team's fixed-width radix-8 Booth multiplier.
- Adds the following over the previous block:
  - valid/ready handshakes on input and output
  - signed and unsigned operand modes
  - a precomputed hard multiple (3A)
  - correct group count for any width
  - an optional accumulate mode
- Intended as the per-PE arithmetic core of the systolic-array matrix multiplier: it consumes one operand pair per transaction and emits one result.

Parameters:
- N, 8, operand width in bits; legal range 4 to 32.
- ACC_W, 2*N+8, accumulator/result width in bits; must be at least 2*N+2.
- G (localparam), (N+3)/3 integer division, number of Booth groups (equals ceil((N+1)/3)).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  high only in IDLE.
- a  input  N  multiplicand.
- b  input  N  multiplier (Booth-recoded operand).
- is_signed  input  1  1 means a and b are two's complement; 0 means unsigned.
- acc_mode  input  1  1 means result = previous result + a*b; 0 means result = a*b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  ACC_W  product or accumulated sum, two's complement.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE
  - in_ready = 1, out_valid = 0, busy = 0
  - result = 0
  - internal accumulator, group counter and multiple registers = 0
- Reset mid-operation aborts the transaction; no result is produced.

- States: IDLE, PRECOMP, RUN, DONE.

- IDLE:
  - Acceptance occurs when in_valid && in_ready.
  - On acceptance, latch a, b, is_signed and acc_mode. Go to PRECOMP.

- PRECOMP (1 cycle):
  - Extend a to N+1 bits: sign-extend if is_signed, zero-extend otherwise. Register A, 2A, 3A and 4A, each sign-extended to ACC_W.
  - Build recode vector R, width 3*G+1:
    - R[0] = 0
    - R[N:1] = b
    - upper bits = b[N-1] if is_signed, else 0
  - Clear the working sum. Clear the group counter k.
  - Go to RUN.

- RUN (exactly G cycles, k = 0..G-1):
  - Booth digit d = -4*R[3k+3] + 2*R[3k+2] + R[3k+1] + R[3k], giving d in {-4..+4}.
  - Select 0, ±A, ±2A, ±3A or ±4A. Negation is two's complement at ACC_W.
  - sum += selected multiple << 3k, all arithmetic modulo 2^ACC_W.
  - After k = G-1, go to DONE.

- DONE entry (the same edge that leaves RUN):
  - result = sum if the latched acc_mode = 0.
  - result = result + sum if acc_mode = 1, wrapping modulo 2^ACC_W with no saturation.
  - out_valid = 1.

- DONE:
  - Hold out_valid and result stable until out_ready.
  - On out_valid && out_ready: out_valid deasserts the next cycle and state returns to IDLE. result keeps its value, which is the accumulation base for the next acc_mode = 1 operation.

- Latency: acceptance edge to out_valid high is G+1 cycles (PRECOMP plus G RUN cycles). For N=8, G=3, so the latency is 4 cycles.
- Throughput: one transaction per G+3 cycles when out_ready is held high.
- in_ready is combinationally (state == IDLE). There is no input bypass.
- The next acceptance is possible in the cycle after the output handshake.
- Inputs a, b and the mode pins may change freely while busy; only the values latched at acceptance are used.
- Unsigned result is zero-extended to ACC_W; signed result is sign-extended.
- Once out_valid rises, result must not change before the handshake, even if reset is not asserted and the inputs toggle.

Test Plan:
- N=8, signed, a=-128, b=-128, acc_mode=0 -> result=16384. out_valid rises exactly 4 cycles after acceptance.
- N=8, unsigned, a=255, b=255 -> result=65025. Repeat with signed, a=-1, b=-1 -> result=1. Sweep all 65536 pairs per mode against a reference model.
- N=8, signed, acc_mode=0 with 7*-3, then acc_mode=1 with 100*100, then acc_mode=1 with -128*127 -> results -21, 9979, -6277, each sign-extended to 24 bits.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stable; in_ready=0 throughout. Raise out_ready -> in_ready=1 on the next cycle.
- Assert reset during RUN (k=1) -> result=0, out_valid=0, in_ready=1 immediately. A new operation 3*5 afterwards -> 15.
- N=16 (G=6), ACC_W=40: signed -32768*-32768 = 1073741824 and unsigned 65535*65535 = 4294836225. Latency is 7 cycles.
